// File: rtl/cpu_pkg.sv
// Shared CPU definitions: branch FSM state encoding, branch opcodes and the
// branch target helper used by branch_unit.
package cpu_pkg;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_CMP  = 2'd1;
    localparam state_t ST_DEC  = 2'd2;
    localparam state_t ST_WB   = 2'd3;

    localparam logic [5:0] OP_BLTZ = 6'd1;
    localparam logic [5:0] OP_BEQ  = 6'd4;
    localparam logic [5:0] OP_BNE  = 6'd5;
    localparam logic [5:0] OP_BLEZ = 6'd6;
    localparam logic [5:0] OP_BGTZ = 6'd7;

    // Word offset is sign-extended and scaled to bytes; the add wraps mod 2^32.
    function automatic logic [31:0] branch_target(input logic [31:0] pc4,
                                                  input logic [15:0] offs);
        return pc4 + {{14{offs[15]}}, offs, 2'b00};
    endfunction

endpackage

// File: rtl/branch_cmp.sv
// Combinational signed comparator for the branch unit.
module branch_cmp
    import cpu_pkg::*;
(
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    output logic        igual_o,
    output logic        maior_o,
    output logic        menor_o
);

    // Signed relation of a_i against b_i.
    always_comb begin
        igual_o = (a_i == b_i);
        maior_o = ($signed(a_i) > $signed(b_i));
        menor_o = ($signed(a_i) < $signed(b_i));
    end

endmodule

// File: rtl/branch_unit.sv
// Multi-cycle branch resolution unit: latch, compare, decide, write back.
// Optional branch statistics counters are built when BRANCH_STATS_EN is defined.
//
// state | meaning
// IDLE  | waiting for start; operands latched when start is seen
// CMP   | register comparison flags and branch target
// DEC   | register taken and the resolved next PC
// WB    | done pulse, PC load strobe when taken
module branch_unit
    import cpu_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [5:0]        opcode,
    input  logic [31:0]       rs_val,
    input  logic [31:0]       rt_val,
    input  logic [31:0]       pc_plus4,
    input  logic [15:0]       imm,
    output logic              busy,
    output logic              done,
    output logic              pc_write,
    output logic [31:0]       pc_next,
    output logic              taken
`ifdef BRANCH_STATS_EN
    ,
    output logic [CNT_W-1:0]  taken_cnt,
    output logic [CNT_W-1:0]  not_taken_cnt
`endif
);

    if (CNT_W < 1) begin : g_bad_cnt_w
        $error("branch_unit: CNT_W must be at least 1");
    end

    state_t      state_q, state_d;
    logic [5:0]  op_q;
    logic [31:0] rs_q, rt_q, pc4_q;
    logic [15:0] imm_q;
    logic        igual_q, maior_q, menor_q;
    logic [31:0] target_q;
    logic        taken_q, taken_d;
    logic [31:0] pc_next_q;
    logic [31:0] cmp_b;
    logic        igual_c, maior_c, menor_c;

    // Two-operand branches compare against rt, the rest against zero.
    assign cmp_b = (op_q == OP_BEQ || op_q == OP_BNE) ? rt_q : 32'd0;

    branch_cmp u_cmp (
        .a_i     (rs_q),
        .b_i     (cmp_b),
        .igual_o (igual_c),
        .maior_o (maior_c),
        .menor_o (menor_c)
    );

    // Fixed four-step sequence; start is only looked at in IDLE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (start) state_d = ST_CMP;
            ST_CMP:  state_d = ST_DEC;
            ST_DEC:  state_d = ST_WB;
            default: state_d = ST_IDLE;
        endcase
    end

    // Branch decision from the registered flags; unknown opcodes never branch.
    always_comb begin
        taken_d = 1'b0;
        case (op_q)
            OP_BEQ:  taken_d = igual_q;
            OP_BNE:  taken_d = ~igual_q;
            OP_BLEZ: taken_d = ~maior_q;
            OP_BGTZ: taken_d = maior_q;
            OP_BLTZ: taken_d = menor_q;
            default: taken_d = 1'b0;
        endcase
    end

    // State, operand, flag and result registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            op_q      <= '0;
            rs_q      <= '0;
            rt_q      <= '0;
            pc4_q     <= '0;
            imm_q     <= '0;
            igual_q   <= 1'b0;
            maior_q   <= 1'b0;
            menor_q   <= 1'b0;
            target_q  <= '0;
            taken_q   <= 1'b0;
            pc_next_q <= '0;
        end else begin
            state_q <= state_d;
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        op_q  <= opcode;
                        rs_q  <= rs_val;
                        rt_q  <= rt_val;
                        pc4_q <= pc_plus4;
                        imm_q <= imm;
                    end
                end
                ST_CMP: begin
                    igual_q  <= igual_c;
                    maior_q  <= maior_c;
                    menor_q  <= menor_c;
                    target_q <= branch_target(pc4_q, imm_q);
                end
                ST_DEC: begin
                    // Results change only here, so they hold from WB until the next WB.
                    taken_q   <= taken_d;
                    pc_next_q <= taken_d ? target_q : pc4_q;
                end
                default: ;
            endcase
        end
    end

    assign busy     = (state_q != ST_IDLE);
    assign done     = (state_q == ST_WB);
    assign pc_write = done & taken_q;
    assign pc_next  = pc_next_q;
    assign taken    = taken_q;

`ifdef BRANCH_STATS_EN
    logic [CNT_W-1:0] taken_cnt_q, not_taken_cnt_q;
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    // Saturating outcome counters, bumped once per resolved branch.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            taken_cnt_q     <= '0;
            not_taken_cnt_q <= '0;
        end else if (state_q == ST_WB) begin
            if (taken_q) begin
                if (taken_cnt_q != CNT_MAX) taken_cnt_q <= taken_cnt_q + CNT_ONE;
            end else begin
                if (not_taken_cnt_q != CNT_MAX) not_taken_cnt_q <= not_taken_cnt_q + CNT_ONE;
            end
        end
    end

    assign taken_cnt     = taken_cnt_q;
    assign not_taken_cnt = not_taken_cnt_q;
`endif

endmodule

// File: tb/tb_branch_unit.sv
// Self-checking bench for branch_unit (counters checked when BRANCH_STATS_EN is defined).
module tb_branch_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [5:0]  opcode = '0;
    logic [31:0] rs_val = '0, rt_val = '0, pc_plus4 = '0;
    logic [15:0] imm = '0;
    logic        busy, done, pc_write, taken;
    logic [31:0] pc_next;
`ifdef BRANCH_STATS_EN
    logic [1:0]  taken_cnt, not_taken_cnt;
`endif

    int checks = 0;
    int failures = 0;
    int exp_tc = 0;
    int exp_ntc = 0;

    branch_unit #(.CNT_W(2)) dut (
        .clk           (clk),
        .reset         (reset),
        .start         (start),
        .opcode        (opcode),
        .rs_val        (rs_val),
        .rt_val        (rt_val),
        .pc_plus4      (pc_plus4),
        .imm           (imm),
        .busy          (busy),
        .done          (done),
        .pc_write      (pc_write),
        .pc_next       (pc_next),
        .taken         (taken)
`ifdef BRANCH_STATS_EN
        ,
        .taken_cnt     (taken_cnt),
        .not_taken_cnt (not_taken_cnt)
`endif
    );

    always #5 clk = ~clk;

    // Reference: branch rules on signed integers.
    function automatic logic model_taken(input logic [5:0] op, input logic [31:0] rs, input logic [31:0] rt);
        int a, b;
        a = rs;
        b = rt;
        case (op)
            6'd4: return a == b;
            6'd5: return a != b;
            6'd6: return a <= 0;
            6'd7: return a > 0;
            6'd1: return a < 0;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [31:0] model_pc(input logic tk, input logic [31:0] pc4, input logic [15:0] im);
        int off;
        off = int'($signed(im));
        return tk ? pc4 + 32'(off * 4) : pc4;
    endfunction

    function automatic void model_count(input logic tk);
        if (tk) exp_tc = (exp_tc < 3) ? exp_tc + 1 : 3;
        else    exp_ntc = (exp_ntc < 3) ? exp_ntc + 1 : 3;
    endfunction

    task automatic launch(input logic [5:0] op, input logic [31:0] rs, input logic [31:0] rt,
                          input logic [31:0] pc4, input logic [15:0] im);
        @(negedge clk);
        opcode = op; rs_val = rs; rt_val = rt; pc_plus4 = pc4; imm = im; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Bounded wait for done; lat counts cycles after the start cycle.
    task automatic wait_done(output int lat, output logic tk, output logic pw, output logic [31:0] pn);
        lat = 1;
        while (done !== 1'b1 && lat < 12) begin
            @(negedge clk);
            lat++;
        end
        tk = taken; pw = pc_write; pn = pc_next;
    endtask

    task automatic test_reset();
        int lat; logic tk, pw; logic [31:0] pn;
        reset = 1'b0;
        #12;
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b want=0", busy); end
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b want=0", done); end
        checks++; if (pc_write !== 1'b0) begin failures++; $display("FAIL reset_pc_write got=%b want=0", pc_write); end
        checks++; if (taken !== 1'b0) begin failures++; $display("FAIL reset_taken got=%b want=0", taken); end
        checks++; if (pc_next !== 32'd0) begin failures++; $display("FAIL reset_pc_next got=%h want=0", pc_next); end
`ifdef BRANCH_STATS_EN
        checks++; if (taken_cnt !== 2'd0 || not_taken_cnt !== 2'd0) begin failures++; $display("FAIL reset_cnt got=%0d/%0d want=0/0", taken_cnt, not_taken_cnt); end
`endif
        exp_tc = 0; exp_ntc = 0;
        // Start presented together with reset release must be taken at the first edge.
        @(negedge clk);
        reset = 1'b1;
        opcode = 6'd4; rs_val = 32'd9; rt_val = 32'd9; pc_plus4 = 32'h1000; imm = 16'h0001; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(lat, tk, pw, pn);
        model_count(1'b1);
        checks++; if (lat != 3) begin failures++; $display("FAIL first_start_latency got=%0d want=3", lat); end
        checks++; if (pn !== 32'h1004) begin failures++; $display("FAIL first_start_pc got=%h want=00001004", pn); end
    endtask

    task automatic test_beq_taken();
        int lat; logic tk, pw; logic [31:0] pn;
        launch(6'd4, 32'd5, 32'd5, 32'h100, 16'h0003);
        wait_done(lat, tk, pw, pn);
        model_count(1'b1);
        checks++; if (lat != 3) begin failures++; $display("FAIL beq_latency got=%0d want=3", lat); end
        checks++; if (tk !== 1'b1) begin failures++; $display("FAIL beq_taken got=%b want=1", tk); end
        checks++; if (pw !== 1'b1) begin failures++; $display("FAIL beq_pc_write got=%b want=1", pw); end
        checks++; if (pn !== 32'h10C) begin failures++; $display("FAIL beq_pc_next got=%h want=0000010c", pn); end
    endtask

    task automatic test_bne_not_taken();
        int lat; logic tk, pw; logic [31:0] pn;
        launch(6'd5, 32'd7, 32'd7, 32'h200, 16'hFFFF);
        wait_done(lat, tk, pw, pn);
        model_count(1'b0);
        checks++; if (tk !== 1'b0) begin failures++; $display("FAIL bne_taken got=%b want=0", tk); end
        checks++; if (pw !== 1'b0) begin failures++; $display("FAIL bne_pc_write got=%b want=0", pw); end
        checks++; if (pn !== 32'h200) begin failures++; $display("FAIL bne_pc_next got=%h want=00000200", pn); end
    endtask

    task automatic test_negative_rs();
        int lat; logic tk, pw; logic [31:0] pn;
        launch(6'd1, 32'hFFFF_FFFF, 32'd0, 32'h40, 16'hFFFE);
        wait_done(lat, tk, pw, pn);
        model_count(1'b1);
        checks++; if (tk !== 1'b1) begin failures++; $display("FAIL bltz_taken got=%b want=1", tk); end
        checks++; if (pn !== 32'h38) begin failures++; $display("FAIL bltz_pc_next got=%h want=00000038", pn); end
        launch(6'd6, 32'hFFFF_FFFF, 32'd0, 32'h40, 16'hFFFE);
        wait_done(lat, tk, pw, pn);
        model_count(1'b1);
        checks++; if (tk !== 1'b1) begin failures++; $display("FAIL blez_taken got=%b want=1", tk); end
        checks++; if (pn !== 32'h38) begin failures++; $display("FAIL blez_pc_next got=%h want=00000038", pn); end
    endtask

    task automatic test_start_while_busy();
        int dones;
        dones = 0;
        launch(6'd7, 32'd0, 32'd0, 32'h80, 16'h0010);
        // Now in CMP: a second start that would branch if accepted.
        opcode = 6'd7; rs_val = 32'd5; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        if (done === 1'b1) dones++;
        checks++; if (done !== 1'b1) begin failures++; $display("FAIL busy_start_done got=%b want=1", done); end
        checks++; if (taken !== 1'b0) begin failures++; $display("FAIL bgtz_taken got=%b want=0", taken); end
        checks++; if (pc_next !== 32'h80) begin failures++; $display("FAIL bgtz_pc_next got=%h want=00000080", pc_next); end
        model_count(1'b0);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL wb_start_busy got=%b want=0", busy); end
        repeat (8) begin
            @(negedge clk);
            if (done === 1'b1) dones++;
        end
        checks++; if (dones != 1) begin failures++; $display("FAIL busy_start_done_count got=%0d want=1", dones); end
    endtask

    task automatic test_reset_mid_op();
        int lat, seen; logic tk, pw; logic [31:0] pn;
        seen = 0;
        launch(6'd4, 32'd3, 32'd3, 32'h500, 16'h0004);
        @(negedge clk);
        reset = 1'b0;
        #1;
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL midreset_busy got=%b want=0", busy); end
        checks++; if (taken !== 1'b0 || pc_write !== 1'b0 || done !== 1'b0) begin failures++; $display("FAIL midreset_flags got=%b%b%b want=000", taken, pc_write, done); end
        checks++; if (pc_next !== 32'd0) begin failures++; $display("FAIL midreset_pc_next got=%h want=0", pc_next); end
        exp_tc = 0; exp_ntc = 0;
`ifdef BRANCH_STATS_EN
        checks++; if (taken_cnt !== 2'd0 || not_taken_cnt !== 2'd0) begin failures++; $display("FAIL midreset_cnt got=%0d/%0d want=0/0", taken_cnt, not_taken_cnt); end
`endif
        repeat (5) begin
            @(negedge clk);
            if (done === 1'b1) seen++;
        end
        checks++; if (seen != 0) begin failures++; $display("FAIL midreset_done_seen got=%0d want=0", seen); end
        reset = 1'b1;
        launch(6'd4, 32'd3, 32'd3, 32'h500, 16'h0004);
        wait_done(lat, tk, pw, pn);
        model_count(1'b1);
        checks++; if (lat != 3 || tk !== 1'b1 || pn !== 32'h510) begin failures++; $display("FAIL after_reset_branch got=lat%0d tk%b pc%h want=lat3 tk1 pc00000510", lat, tk, pn); end
    endtask

    task automatic test_random();
        logic [5:0] ops [8];
        logic [5:0] op; logic [31:0] rs, rt, pc4; logic [15:0] im;
        logic exp_tk; logic [31:0] exp_pc;
        int lat; logic tk, pw; logic [31:0] pn;
        ops = '{6'd1, 6'd4, 6'd5, 6'd6, 6'd7, 6'd0, 6'd2, 6'd63};
        for (int i = 0; i < 40; i++) begin
            op  = ops[$urandom_range(7, 0)];
            rs  = ($urandom_range(2, 0) == 0) ? 32'($urandom_range(4, 0)) - 32'd2 : $urandom;
            rt  = ($urandom_range(1, 0) == 0) ? rs : $urandom;
            pc4 = $urandom & 32'hFFFF_FFFC;
            im  = 16'($urandom);
            exp_tk = model_taken(op, rs, rt);
            exp_pc = model_pc(exp_tk, pc4, im);
            launch(op, rs, rt, pc4, im);
            wait_done(lat, tk, pw, pn);
            model_count(exp_tk);
            checks++; if (lat != 3) begin failures++; $display("FAIL rand_latency[%0d] got=%0d want=3", i, lat); end
            checks++; if (tk !== exp_tk || pw !== exp_tk) begin failures++; $display("FAIL rand_taken[%0d] op=%0d got=%b/%b want=%b", i, op, tk, pw, exp_tk); end
            checks++; if (pn !== exp_pc) begin failures++; $display("FAIL rand_pc_next[%0d] got=%h want=%h", i, pn, exp_pc); end
            repeat ($urandom_range(2, 1)) @(negedge clk);
            checks++; if (done !== 1'b0 || pc_write !== 1'b0 || taken !== exp_tk || pc_next !== exp_pc) begin
                failures++; $display("FAIL rand_hold[%0d] got=d%b w%b t%b pc%h want=d0 w0 t%b pc%h", i, done, pc_write, taken, pc_next, exp_tk, exp_pc);
            end
`ifdef BRANCH_STATS_EN
            checks++; if (int'(taken_cnt) != exp_tc || int'(not_taken_cnt) != exp_ntc) begin failures++; $display("FAIL rand_cnt[%0d] got=%0d/%0d want=%0d/%0d", i, taken_cnt, not_taken_cnt, exp_tc, exp_ntc); end
`endif
        end
    endtask

`ifdef BRANCH_STATS_EN
    task automatic test_stats_saturate();
        int lat; logic tk, pw; logic [31:0] pn;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        exp_tc = 0; exp_ntc = 0;
        repeat (5) begin
            launch(6'd4, 32'd1, 32'd1, 32'h20, 16'h0001);
            wait_done(lat, tk, pw, pn);
            model_count(1'b1);
        end
        @(negedge clk);
        checks++; if (int'(taken_cnt) != exp_tc) begin failures++; $display("FAIL stats_taken_cnt got=%0d want=%0d", taken_cnt, exp_tc); end
        checks++; if (int'(not_taken_cnt) != exp_ntc) begin failures++; $display("FAIL stats_not_taken_cnt got=%0d want=%0d", not_taken_cnt, exp_ntc); end
    endtask
`endif

    initial begin
        test_reset();
        test_beq_taken();
        test_bne_not_taken();
        test_negative_rs();
        test_start_while_busy();
        test_reset_mid_op();
        test_random();
`ifdef BRANCH_STATS_EN
        test_stats_saturate();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
